// File: rtl/snn_pkg.sv
// snn_pkg: shared widths, limits and LIF FSM state encoding
package snn_pkg;
  localparam int V_W = 16;
  localparam int W_W = 8;
  localparam int CNT_W = 16;
  localparam logic signed [V_W-1:0] V_MAX = 16'sd32767;
  typedef enum logic {INTEGRATE, REFRAC} lif_state_e;
endpackage

// File: rtl/lif_sat_add.sv
// lif_sat_add: leak subtract plus gated 3-weight add, clamped to 0..V_MAX
module lif_sat_add
  import snn_pkg::*;
#(
  parameter int LEAK_SHIFT = 4
) (
  input  logic signed [V_W-1:0] v,
  input  logic                  r_sp,
  input  logic                  g_sp,
  input  logic                  b_sp,
  input  logic signed [W_W-1:0] w_r,
  input  logic signed [W_W-1:0] w_g,
  input  logic signed [W_W-1:0] w_b,
  output logic signed [V_W-1:0] sum
);
  localparam int S_W = V_W + 2;
  logic signed [S_W-1:0] s;
  // two guard bits keep the worst-case sum from wrapping before the clamp
  always_comb begin
    s = S_W'(v) - S_W'(v >>> LEAK_SHIFT)
      + (r_sp ? S_W'(w_r) : S_W'(0))
      + (g_sp ? S_W'(w_g) : S_W'(0))
      + (b_sp ? S_W'(w_b) : S_W'(0));
    sum = s < 0 ? '0 : (s > S_W'(V_MAX) ? V_MAX : s[V_W-1:0]);
  end
endmodule

// File: rtl/lif_neuron.sv
// lif_neuron: leaky integrate-and-fire neuron; define LIF_REFRACTORY_EN for a refractory period
module lif_neuron
  import snn_pkg::*;
#(
  parameter int LEAK_SHIFT = 4,
  parameter int REFRAC_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    r_sp,
  input  logic                    g_sp,
  input  logic                    b_sp,
  input  logic                    en,
  input  logic signed [W_W-1:0]   w_r,
  input  logic signed [W_W-1:0]   w_g,
  input  logic signed [W_W-1:0]   w_b,
  input  logic signed [V_W-1:0]   threshold,
  input  logic                    clr_count,
  output logic                    out_spike,
  output logic signed [V_W-1:0]   v_mem,
  output logic [CNT_W-1:0]        spike_count,
  output logic                    refractory
);
  lif_state_e state, state_n;
  logic signed [V_W-1:0] sum, v_n;
  logic fire;
  lif_sat_add #(.LEAK_SHIFT(LEAK_SHIFT)) u_add (
    .v(v_mem), .r_sp(r_sp), .g_sp(g_sp), .b_sp(b_sp),
    .w_r(w_r), .w_g(w_g), .w_b(w_b), .sum(sum)
  );
  assign fire = en && state == INTEGRATE && sum >= threshold;
`ifdef LIF_REFRACTORY_EN
  logic [7:0] rc;
  logic rc_last;
  assign rc_last = rc == 8'(REFRAC_CYCLES - 1);
  // refractory cycle counter, frozen while en is low
  always_ff @(posedge clk) begin
    if (reset) rc <= '0;
    else if (en && state == REFRAC) rc <= rc_last ? '0 : rc + 8'd1;
  end
  // refractory flag mirrors the registered state
  always_ff @(posedge clk) begin
    if (reset) refractory <= 1'b0;
    else refractory <= state_n == REFRAC;
  end
`else
  assign refractory = 1'b0;
`endif
  // next membrane value and state
  always_comb begin
    state_n = state;
    v_n = v_mem;
    if (en && state == INTEGRATE) begin
      v_n = fire ? '0 : sum;
`ifdef LIF_REFRACTORY_EN
      state_n = fire ? REFRAC : INTEGRATE;
    end else if (en) begin
      v_n = '0;
      state_n = rc_last ? INTEGRATE : REFRAC;
`endif
    end
  end
  // state, membrane and fire pulse registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= INTEGRATE;
      v_mem <= '0;
      out_spike <= 1'b0;
    end else begin
      state <= state_n;
      v_mem <= v_n;
      out_spike <= fire;
    end
  end
  // saturating fire counter; clear beats a coincident fire
  always_ff @(posedge clk) begin
    if (reset || clr_count) spike_count <= '0;
    else if (fire && spike_count != '1) spike_count <= spike_count + 1'b1;
  end
endmodule
